pixel_streamer: RTL and testbench

Frame-read front end for the convolution datapath. On `start` it reads an IMG_HEIGHT x IMG_WIDTH image from a synchronous-read pixel memory in raster order and emits it as a valid/ready pixel stream with frame and line markers. With `out_ready` tied high, `out_valid`/`pixel_out` drive the line buffer's `in_valid`/`pixel_in` directly at one pixel per cycle.

---
 rtl/pixel_streamer_pkg.sv | 21 ++
 rtl/pixel_streamer_stream_fifo2.sv | 46 ++++
 rtl/pixel_streamer.sv | 121 ++++++++++++
 tb/tb_pixel_streamer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_streamer_pkg.sv
// Shared types and default sizing for the frame-read front end.
package pixel_streamer_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_WIDTH  = 28;
  localparam int DEF_IMG_HEIGHT = 28;
  localparam int DEF_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bits needed to hold values 0..v (never less than 1).
  function automatic int cnt_width(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/pixel_streamer_stream_fifo2.sv
// Two-entry register FIFO between the pixel memory read port and the output stream.
module pixel_streamer_stream_fifo2
  import pixel_streamer_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot0  <= '0;
      slot1  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) slot1 <= din;
        else        slot0 <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Push always targets the non-head slot, so the head is stable while stalled.
  assign head = rd_ptr ? slot1 : slot0;

endmodule

// File: rtl/pixel_streamer.sv
// Reads an image from synchronous-read pixel memory in raster order and emits it
// as a valid/ready pixel stream with sof/eol/eof markers.
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | issuing reads, one per free FIFO slot
// DRAIN  | all reads issued, emptying FIFO up to the eof handshake
// DONE   | one-cycle done pulse, start ignored
module pixel_streamer
  import pixel_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] pixel_out,
  output logic                         sof,
  output logic                         eol,
  output logic                         eof,
  output logic                         busy,
  output logic                         done
);

  localparam int N     = IMG_WIDTH * IMG_HEIGHT;
  localparam int IDX_W = cnt_width(N);
  localparam int COL_W = cnt_width(IMG_WIDTH);
  localparam int ROW_W = cnt_width(IMG_HEIGHT);

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [IDX_W-1:0]      rd_idx;
  logic                  inflight;
  logic [COL_W-1:0]      out_col;
  logic [ROW_W-1:0]      out_row;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  hs;
  logic [2:0]            occ;
  logic                  col_last;
  logic                  row_last;

  pixel_streamer_stream_fifo2 #(.WIDTH(DATA_WIDTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (inflight),
    .pop     (hs),
    .din     (mem_rd_data),
    .count   (fifo_count),
    .head    (fifo_head)
  );

  assign out_valid = (fifo_count != 2'd0);
  assign pixel_out = fifo_head;
  assign hs        = out_valid & out_ready;

  // Occupancy counts data already in flight, so two slots can never be overcommitted.
  assign occ       = {1'b0, fifo_count} + {2'b00, inflight};
  assign mem_rd_en = (state == ST_STREAM) && (occ < (3'd2 + {2'b00, hs}));
  assign mem_addr  = base_q + ADDR_WIDTH'(rd_idx);

  assign col_last = (out_col == COL_W'(IMG_WIDTH - 1));
  assign row_last = (out_row == ROW_W'(IMG_HEIGHT - 1));
  assign sof      = out_valid && (out_col == '0) && (out_row == '0);
  assign eol      = out_valid && col_last;
  assign eof      = out_valid && col_last && row_last;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      base_q   <= '0;
      rd_idx   <= '0;
      inflight <= 1'b0;
      out_col  <= '0;
      out_row  <= '0;
    end else begin
      inflight <= mem_rd_en;
      if (mem_rd_en) rd_idx <= rd_idx + 1'b1;
      if (hs) begin
        if (col_last) begin
          out_col <= '0;
          out_row <= out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_STREAM;
            base_q  <= base_addr;
            rd_idx  <= '0;
            out_col <= '0;
            out_row <= '0;
          end
        end
        ST_STREAM: begin
          if (mem_rd_en && (rd_idx == IDX_W'(N - 1))) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (hs && eof) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_streamer.sv
// Scoreboard bench for pixel_streamer on a 4x3 image with a behavioural memory and stream model.
module tb_pixel_streamer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    logic       eof;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [15:0]       base_addr;
  logic              mem_rd_en;
  logic [15:0]       mem_addr;
  logic [7:0]        mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] pixel_out;
  logic              sof, eol, eof, busy, done;

  pixel_streamer #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .pixel_out(pixel_out),
    .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory: memory[a] = a & 0xFF, data one cycle after the strobe.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_addr[7:0];

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];
  logic [15:0] frame_base = '0;
  int rd_cnt = 0;
  int tb_occ = 0;
  logic mon_en = 1'b0;
  logic prev_stall = 1'b0;
  logic [10:0] prev_out = '0;
  int pix_cnt = 0, done_cnt = 0, busy_cnt = 0;
  int sof_cyc = 0, eof_cyc = 0, done_cyc = 0;
  int rdy_mode = 0;
  int rdy_phase = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [15:0] base);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.pix = 8'((int'(base) + i) & 255);
      e.sof = (i == 0);
      e.eol = ((i % W) == W - 1);
      e.eof = (i == N - 1);
      exp_q.push_back(e);
    end
    frame_base = base;
    rd_cnt = 0;
  endtask

  task automatic monitor();
    exp_t e;
    logic hs;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        hs = out_valid && out_ready;
        if (prev_stall) begin
          chk("stall_valid_hold", {31'b0, out_valid}, 32'd1);
          chk("stall_data_hold", {21'b0, pixel_out, sof, eol, eof}, {21'b0, prev_out});
        end
        if (mem_rd_en) begin
          chk("rd_room", {31'b0, (tb_occ - (hs ? 1 : 0)) < 2}, 32'd1);
          chk("rd_addr", {16'b0, mem_addr}, {16'b0, 16'(int'(frame_base) + rd_cnt)});
          rd_cnt++;
        end
        if (hs) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_pixel: got %0h expected none (cycle %0d)", pixel_out, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("pixel", {24'b0, pixel_out}, {24'b0, e.pix});
            chk("sof", {31'b0, sof}, {31'b0, e.sof});
            chk("eol", {31'b0, eol}, {31'b0, e.eol});
            chk("eof", {31'b0, eof}, {31'b0, e.eof});
          end
          pix_cnt++;
          if (sof) sof_cyc = cyc;
          if (eof) eof_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        tb_occ = tb_occ + (mem_rd_en ? 1 : 0) - (hs ? 1 : 0);
        prev_stall = out_valid && !out_ready;
        prev_out = {pixel_out, sof, eol, eof};
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (rdy_phase == 0);
          rdy_phase = (rdy_phase + 1) % 3;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic start_frame(input logic [15:0] base, output int c0);
    @(posedge clk);
    #1;
    push_frame(base);
    base_addr = base;
    start = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
    end
    chk("done_seen", {31'b0, done_cnt != d0}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rd_en"}, {31'b0, mem_rd_en}, 32'd0);
    chk({tag, "_addr"}, {16'b0, mem_addr}, 32'd0);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_pixel"}, {24'b0, pixel_out}, 32'd0);
    chk({tag, "_markers"}, {29'b0, sof, eol, eof}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int c0, p0, d0, b0;
    reset_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    out_ready = 1'b1;
    fork
      monitor();
      ready_driver();
    join_none
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset");
    reset_n = 1'b1;
    mon_en = 1'b1;

    // Full-rate frame: latency, throughput, done timing, then start during DONE.
    rdy_mode = 0;
    p0 = pix_cnt; d0 = done_cnt; b0 = busy_cnt;
    start_frame(16'h0010, c0);
    #1;
    chk("lat_busy", {31'b0, busy}, 32'd1);
    chk("lat_rd_en", {31'b0, mem_rd_en}, 32'd1);
    chk("lat_addr", {16'b0, mem_addr}, 32'h0010);
    wait_done(200);
    chk("t1_sof_cycle", sof_cyc - c0, 32'd3);
    chk("t1_eof_cycle", eof_cyc - c0, 32'd14);
    chk("t1_done_cycle", done_cyc - c0, 32'd15);
    chk("t1_pixels", pix_cnt - p0, N);
    chk("t1_busy_cycles", busy_cnt - b0, 32'd15);
    chk("t1_done_pulses", done_cnt - d0, 32'd1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    chk("start_in_done_ignored", {31'b0, busy}, 32'd0);
    chk("t1_queue_empty", exp_q.size(), 32'd0);

    // Backpressure 1,0,0 pattern.
    rdy_mode = 1;
    rdy_phase = 0;
    p0 = pix_cnt; d0 = done_cnt;
    start_frame(16'h0010, c0);
    wait_done(300);
    chk("bp_pixels", pix_cnt - p0, N);
    chk("bp_done_pulses", done_cnt - d0, 32'd1);
    chk("bp_queue_empty", exp_q.size(), 32'd0);

    // Address wrap-around.
    rdy_mode = 0;
    p0 = pix_cnt;
    start_frame(16'hFFFE, c0);
    wait_done(200);
    chk("wrap_pixels", pix_cnt - p0, N);

    // Start re-pulsed mid-frame with a different base.
    p0 = pix_cnt; d0 = done_cnt;
    start_frame(16'h0010, c0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 16'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);
    repeat (5) @(negedge clk);
    chk("repulse_pixels", pix_cnt - p0, N);
    chk("repulse_done_pulses", done_cnt - d0, 32'd1);
    chk("repulse_idle", {31'b0, busy}, 32'd0);

    // Reset in cycle 7 of a frame.
    start_frame(16'h0010, c0);
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete();
    tb_occ = 0;
    prev_stall = 1'b0;
    chk("rst_cycle", cyc - c0, 32'd8);
    check_reset_vals("midrst");
    @(posedge clk); #2;
    chk("late_read_dropped", {31'b0, out_valid}, 32'd0);
    p0 = pix_cnt;
    start_frame(16'h0010, c0);
    wait_done(200);
    chk("post_rst_pixels", pix_cnt - p0, N);
    chk("post_rst_sof_cycle", sof_cyc - c0, 32'd3);

    // Back-to-back frames.
    p0 = pix_cnt;
    start_frame(16'h0020, c0);
    wait_done(200);
    start_frame(16'h0020, c0);
    wait_done(200);
    chk("b2b_sof_cycle", sof_cyc - c0, 32'd3);
    chk("b2b_pixels", pix_cnt - p0, 2 * N);

    // Random bases under random backpressure.
    rdy_mode = 2;
    for (int f = 0; f < 5; f++) begin
      p0 = pix_cnt;
      start_frame(16'($urandom), c0);
      wait_done(800);
      chk("rand_pixels", pix_cnt - p0, N);
      chk("rand_queue_empty", exp_q.size(), 32'd0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
